// File: rtl/fan_ctrl_if.sv
// fan_ctrl_if: bundle of the job-descriptor, vector, tree and result signals of fan_ctrl.
//   master : environment side (drives descriptors, vectors and the tree result fan_out)
//   slave  : fan_ctrl side (drives handshake readies, tree configuration/operand and results)
// Parameters: DW_DATA element width, N reduction-tree leaves.
interface fan_ctrl_if #(
  parameter int unsigned DW_DATA = 8,
  parameter int unsigned N       = 32
);
  // Job descriptor
  logic                         cfg_valid;
  logic                         cfg_ready;
  logic [N-2:0]                 cfg_add_en;
  logic [N-2:0]                 cfg_bypass_en;
  logic [6*(N-1)-1:0]           cfg_sel;
  logic [15:0]                  cfg_len;
  logic                         cfg_err;
  // Input vectors
  logic                         in_valid;
  logic                         in_ready;
  logic [DW_DATA*N-1:0]         in_data;
  // Attached reduction tree
  logic [N-2:0]                 fan_add_en;
  logic [N-2:0]                 fan_bypass_en;
  logic [6*(N-1)-1:0]           fan_sel;
  logic [DW_DATA*N-1:0]         fan_in;
  logic [DW_DATA*2*(N-1)-1:0]   fan_out;
  // Result stream
  logic                         out_valid;
  logic                         out_last;
  logic [DW_DATA*2*(N-1)-1:0]   out_data;

  modport master (
    output cfg_valid, cfg_add_en, cfg_bypass_en, cfg_sel, cfg_len,
    output in_valid, in_data, fan_out,
    input  cfg_ready, cfg_err, in_ready,
    input  fan_add_en, fan_bypass_en, fan_sel, fan_in,
    input  out_valid, out_last, out_data
  );

  modport slave (
    input  cfg_valid, cfg_add_en, cfg_bypass_en, cfg_sel, cfg_len,
    input  in_valid, in_data, fan_out,
    output cfg_ready, cfg_err, in_ready,
    output fan_add_en, fan_bypass_en, fan_sel, fan_in,
    output out_valid, out_last, out_data
  );
endinterface

// File: rtl/fan_ctrl.sv
// fan_ctrl: sequences jobs through an attached fan_tree reduction network.
// A job descriptor (cfg_*) latches the tree configuration and a vector count; cfg_len vectors are
// then accepted on in_*, each registered into fan_in, and the tree result is captured into
// out_data 1+TREE_LAT edges later. out_last marks the final result of the job.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : fan_ctrl_if.slave -- cfg_* descriptor handshake, in_* vector handshake, fan_* tree
//          configuration/operand/result, out_* result stream (no backpressure), cfg_err pulse
// Parameters: DW_DATA element width, N tree leaves, TREE_LAT register stages inside the tree.
// Optional build macro FAN_CTRL_CHECK_EN: descriptors with a bypass enabled on a disabled adder
// are consumed without starting a job and flagged with a one-cycle cfg_err pulse. When the macro
// is undefined no check is made and cfg_err is tied low.
module fan_ctrl #(
  parameter int unsigned DW_DATA  = 8,
  parameter int unsigned N        = 32,
  parameter int unsigned TREE_LAT = 0
) (
  input logic       clk,
  input logic       rst,
  fan_ctrl_if.slave bus
);

  // One slot per edge between fan_in load and out_data capture.
  localparam int unsigned Depth = 1 + TREE_LAT;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                       state_q;
  logic [N-2:0]                 add_en_q;
  logic [N-2:0]                 bypass_en_q;
  logic [6*(N-1)-1:0]           sel_q;
  logic [15:0]                  len_q;
  logic [15:0]                  cnt_q;
  logic [DW_DATA*N-1:0]         fan_in_q;
  logic [DW_DATA*2*(N-1)-1:0]   out_data_q;
  logic                         out_valid_q;
  logic                         out_last_q;
  logic [Depth-1:0]             sr_vld_q;
  logic [Depth-1:0]             sr_last_q;
`ifdef FAN_CTRL_CHECK_EN
  logic                         cfg_err_q;
`endif

  logic cfg_hs;
  logic in_hs;
  logic cfg_bad;
  logic is_last;
  logic sr_done;

  assign bus.cfg_ready = (state_q == StIdle);
  assign bus.in_ready  = (state_q == StRun) && (cnt_q < len_q);

  assign cfg_hs  = bus.cfg_valid && bus.cfg_ready;
  assign in_hs   = bus.in_valid && bus.in_ready;
  assign is_last = (cnt_q == (len_q - 16'd1));
  // Final result of the job leaves the delay line on this edge.
  assign sr_done = sr_vld_q[Depth-1] & sr_last_q[Depth-1];

`ifdef FAN_CTRL_CHECK_EN
  // A bypass on an adder that is not enabled is an inconsistent descriptor.
  assign cfg_bad     = |(bus.cfg_bypass_en & ~bus.cfg_add_en);
  assign bus.cfg_err = cfg_err_q;
`else
  assign cfg_bad     = 1'b0;
  assign bus.cfg_err = 1'b0;
`endif

  assign bus.fan_add_en    = add_en_q;
  assign bus.fan_bypass_en = bypass_en_q;
  assign bus.fan_sel       = sel_q;
  assign bus.fan_in        = fan_in_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_last      = out_last_q;
  assign bus.out_data      = out_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      add_en_q    <= '0;
      bypass_en_q <= '0;
      sel_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      fan_in_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      sr_vld_q    <= '0;
      sr_last_q   <= '0;
`ifdef FAN_CTRL_CHECK_EN
      cfg_err_q   <= 1'b0;
`endif
    end else begin
      // Result capture at the tail of the valid-delay line.
      out_valid_q <= sr_vld_q[Depth-1];
      out_last_q  <= sr_done;
      if (sr_vld_q[Depth-1]) begin
        out_data_q <= bus.fan_out;
      end

      sr_vld_q[0]  <= in_hs;
      sr_last_q[0] <= in_hs & is_last;
      for (int unsigned i = 1; i < Depth; i++) begin
        sr_vld_q[i]  <= sr_vld_q[i-1];
        sr_last_q[i] <= sr_last_q[i-1];
      end

      if (in_hs) begin
        fan_in_q <= bus.in_data;
        cnt_q    <= cnt_q + 16'd1;
      end

`ifdef FAN_CTRL_CHECK_EN
      cfg_err_q <= 1'b0;
`endif

      case (state_q)
        StIdle: begin
          if (cfg_hs) begin
            cnt_q <= '0;
            if (cfg_bad) begin
`ifdef FAN_CTRL_CHECK_EN
              cfg_err_q <= 1'b1;
`endif
            end else if (bus.cfg_len == 16'd0) begin
              // Empty job: terminate immediately with a bare out_last.
              out_last_q <= 1'b1;
            end else begin
              add_en_q    <= bus.cfg_add_en;
              bypass_en_q <= bus.cfg_bypass_en;
              sel_q       <= bus.cfg_sel;
              len_q       <= bus.cfg_len;
              state_q     <= StRun;
            end
          end
        end
        StRun: begin
          if (in_hs && is_last) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (sr_done) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fan_ctrl.sv
// Bench for fan_ctrl: two instances (TREE_LAT=0 and TREE_LAT=2) share one stimulus stream; each
// has its own stand-in reduction tree. A job-level reference model predicts handshakes, the
// result of every accepted vector and the cycle at which it must appear.
module tb_fan_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned N  = 32;
  localparam int IW = DW * N;
  localparam int OW = DW * 2 * (N - 1);
  localparam int AW = N - 1;
  localparam int SW = 6 * (N - 1);

`ifdef FAN_CTRL_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cfg_valid;
  logic [AW-1:0] cfg_add_en;
  logic [AW-1:0] cfg_bypass_en;
  logic [SW-1:0] cfg_sel;
  logic [15:0]   cfg_len;
  logic          in_valid;
  logic [IW-1:0] in_data;

  fan_ctrl_if #(.DW_DATA(DW), .N(N)) bus0 ();
  fan_ctrl_if #(.DW_DATA(DW), .N(N)) bus2 ();

  assign bus0.cfg_valid     = cfg_valid;
  assign bus0.cfg_add_en    = cfg_add_en;
  assign bus0.cfg_bypass_en = cfg_bypass_en;
  assign bus0.cfg_sel       = cfg_sel;
  assign bus0.cfg_len       = cfg_len;
  assign bus0.in_valid      = in_valid;
  assign bus0.in_data       = in_data;
  assign bus2.cfg_valid     = cfg_valid;
  assign bus2.cfg_add_en    = cfg_add_en;
  assign bus2.cfg_bypass_en = cfg_bypass_en;
  assign bus2.cfg_sel       = cfg_sel;
  assign bus2.cfg_len       = cfg_len;
  assign bus2.in_valid      = in_valid;
  assign bus2.in_data       = in_data;

  fan_ctrl #(.DW_DATA(DW), .N(N), .TREE_LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  fan_ctrl #(.DW_DATA(DW), .N(N), .TREE_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Stand-in fan_tree golden: each output element mixes two leaves under the adder's config.
  function automatic logic [OW-1:0] tree_fn(input logic [IW-1:0] x, input logic [AW-1:0] add,
                                            input logic [AW-1:0] byp, input logic [SW-1:0] sel);
    logic [OW-1:0] r;
    logic [7:0] a, b, e;
    int k;
    r = '0;
    for (int j = 0; j < 2 * AW; j++) begin
      k = j % AW;
      a = x[(j % N) * DW +: DW];
      b = x[((j * 7 + 3) % N) * DW +: DW];
      e = add[k] ? a + b : a;
      e = e ^ {2'b00, sel[k * 6 +: 6]};
      if (byp[k]) e = e ^ 8'h80;
      r[j * DW +: DW] = e;
    end
    return r;
  endfunction

  always_comb bus0.fan_out = tree_fn(bus0.fan_in, bus0.fan_add_en, bus0.fan_bypass_en,
                                     bus0.fan_sel);

  logic [OW-1:0] p1, p2;
  always @(posedge clk) begin
    p1 <= tree_fn(bus2.fan_in, bus2.fan_add_en, bus2.fan_bypass_en, bus2.fan_sel);
    p2 <= p1;
  end
  assign bus2.fan_out = p2;

  // Reference model state
  typedef struct {
    int            cyc;
    logic [OW-1:0] data;
    bit            last;
  } ev_t;

  ev_t           q0[$];
  ev_t           q2[$];
  int            cyc;
  bit            run;
  int            acc;
  int            len_m;
  logic [AW-1:0] m_add;
  logic [AW-1:0] m_byp;
  logic [SW-1:0] m_sel;
  logic [IW-1:0] m_fanin;
  bit            busy [2];
  int            zl_cyc;
  int            err_cyc;
  int            hs_count;
  int            checks;
  int            errors;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    run     = 1'b0;
    acc     = 0;
    len_m   = 0;
    m_add   = '0;
    m_byp   = '0;
    m_sel   = '0;
    m_fanin = '0;
    busy[0] = 1'b0;
    busy[1] = 1'b0;
    zl_cyc  = -1;
    err_cyc = -1;
    q0.delete();
    q2.delete();
  endtask

  task automatic check_dut(input int d, input logic ov, input logic ol, input logic [OW-1:0] od,
                           input logic ce, input logic [IW-1:0] fi, input logic [AW-1:0] fa,
                           input logic [AW-1:0] fb, input logic [SW-1:0] fs);
    bit  ev;
    ev_t h;
    ev = 1'b0;
    if (d == 0) begin
      if (q0.size() > 0 && q0[0].cyc == cyc) begin
        ev = 1'b1;
        h  = q0.pop_front();
      end
    end else begin
      if (q2.size() > 0 && q2[0].cyc == cyc) begin
        ev = 1'b1;
        h  = q2.pop_front();
      end
    end
    chk($sformatf("out_valid%0d@%0d", d, cyc), 512'(ov), 512'(ev));
    chk($sformatf("out_last%0d@%0d", d, cyc), 512'(ol), 512'(ev ? h.last : (zl_cyc == cyc)));
    if (ev) begin
      chk($sformatf("out_data%0d@%0d", d, cyc), 512'(od), 512'(h.data));
      if (h.last) busy[d] = 1'b0;
    end
    chk($sformatf("cfg_err%0d@%0d", d, cyc), 512'(ce), 512'(err_cyc == cyc));
    chk($sformatf("fan_in%0d@%0d", d, cyc), 512'(fi), 512'(m_fanin));
    chk($sformatf("fan_add_en%0d@%0d", d, cyc), 512'(fa), 512'(m_add));
    chk($sformatf("fan_bypass_en%0d@%0d", d, cyc), 512'(fb), 512'(m_byp));
    chk($sformatf("fan_sel%0d@%0d", d, cyc), 512'(fs), 512'(m_sel));
  endtask

  // One clock: check readies before the edge, advance the model, check outputs after it.
  task automatic tick();
    bit cfg_hs, in_hs, bad;
    chk($sformatf("cfg_ready0@%0d", cyc), 512'(bus0.cfg_ready), 512'(!run && !busy[0]));
    chk($sformatf("cfg_ready2@%0d", cyc), 512'(bus2.cfg_ready), 512'(!run && !busy[1]));
    chk($sformatf("in_ready0@%0d", cyc), 512'(bus0.in_ready), 512'(run && acc < len_m));
    chk($sformatf("in_ready2@%0d", cyc), 512'(bus2.in_ready), 512'(run && acc < len_m));
    cfg_hs = cfg_valid && !run && !busy[0] && !busy[1] && !rst;
    in_hs  = in_valid && run && (acc < len_m) && !rst;
    @(posedge clk);
    cyc++;
    if (rst) begin
      reset_model();
    end else begin
      if (cfg_hs) begin
        bad = CheckEn && ((cfg_bypass_en & ~cfg_add_en) != '0);
        if (bad) begin
          err_cyc = cyc;
        end else if (cfg_len == 16'd0) begin
          zl_cyc = cyc;
        end else begin
          run     = 1'b1;
          acc     = 0;
          len_m   = int'(cfg_len);
          m_add   = cfg_add_en;
          m_byp   = cfg_bypass_en;
          m_sel   = cfg_sel;
          busy[0] = 1'b1;
          busy[1] = 1'b1;
        end
      end
      if (in_hs) begin
        q0.push_back('{cyc + 1, tree_fn(in_data, m_add, m_byp, m_sel), acc == len_m - 1});
        q2.push_back('{cyc + 3, tree_fn(in_data, m_add, m_byp, m_sel), acc == len_m - 1});
        m_fanin = in_data;
        acc++;
        hs_count++;
        if (acc == len_m) run = 1'b0;
      end
    end
    #1;
    check_dut(0, bus0.out_valid, bus0.out_last, bus0.out_data, bus0.cfg_err, bus0.fan_in,
              bus0.fan_add_en, bus0.fan_bypass_en, bus0.fan_sel);
    check_dut(1, bus2.out_valid, bus2.out_last, bus2.out_data, bus2.cfg_err, bus2.fan_in,
              bus2.fan_add_en, bus2.fan_bypass_en, bus2.fan_sel);
  endtask

  task automatic rnd_in();
    for (int i = 0; i < IW / 32; i++) in_data[i * 32 +: 32] = $urandom;
  endtask

  task automatic rnd_cfg_lines();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i * 32 +: 32] = $urandom;
    cfg_add_en    = r[AW-1:0];
    cfg_bypass_en = r[2*AW-1:AW];
    cfg_sel       = r[SW-1:0];
    cfg_len       = 16'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((run || busy[0] || busy[1]) && n < 200) begin
      tick();
      n++;
    end
    chk("idle_wait_timeout", 512'(run || busy[0] || busy[1]), 512'(0));
  endtask

  task automatic send_cfg(input logic [AW-1:0] add, input logic [AW-1:0] byp,
                          input logic [SW-1:0] sel, input logic [15:0] len);
    wait_idle();
    cfg_add_en    = add;
    cfg_bypass_en = byp;
    cfg_sel       = sel;
    cfg_len       = len;
    cfg_valid     = 1'b1;
    tick();
    cfg_valid = 1'b0;
    // Scramble the descriptor lines: the tree config must come from the latched copy.
    rnd_cfg_lines();
  endtask

  task automatic send_vec(input logic [IW-1:0] v);
    int n, start;
    n         = 0;
    start     = hs_count;
    in_valid  = 1'b1;
    in_data   = v;
    while (hs_count == start && n < 50) begin
      tick();
      n++;
    end
    in_valid = 1'b0;
    chk("send_vec_timeout", 512'(hs_count - start), 512'(1));
  endtask

  initial begin
    logic [IW-1:0] v;
    logic [255:0]  r;
    logic [AW-1:0] add, byp;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    hs_count  = 0;
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    rnd_cfg_lines();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_model();
    tick();
    rst = 1'b0;
    tick();

    // Single vector, elements 0..N-1
    send_cfg('1, '0, '0, 16'd1);
    for (int i = 0; i < int'(N); i++) v[i * DW +: DW] = 8'(i);
    send_vec(v);
    wait_idle();
    tick();

    // Burst of three with in_valid held high
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    send_cfg(r[AW-1:0], r[AW-1:0] & r[2*AW-1:AW], r[SW-1:0], 16'd3);
    hs_count = 0;
    in_valid = 1'b1;
    repeat (5) begin
      rnd_in();
      tick();
    end
    in_valid = 1'b0;
    chk("burst_accepts", 512'(hs_count), 512'(3));
    wait_idle();

    // Bubbles: in_valid toggling
    send_cfg('1, '0, r[SW+5:6], 16'd4);
    hs_count = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = (i % 2 == 0);
      rnd_in();
      tick();
    end
    in_valid = 1'b0;
    chk("bubble_accepts", 512'(hs_count), 512'(4));
    wait_idle();

    // Zero-length job
    send_cfg(r[AW-1:0], '0, r[SW-1:0], 16'd0);
    repeat (2) tick();

    // Reset mid-job after two accepts
    send_cfg(r[AW-1:0], '0, r[SW-1:0], 16'd5);
    hs_count = 0;
    in_valid = 1'b1;
    rnd_in();
    tick();
    rnd_in();
    tick();
    in_valid = 1'b0;
    chk("reset_job_accepts", 512'(hs_count), 512'(2));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();

    // Bypass on a disabled adder
    add      = '1;
    add[2]   = 1'b0;
    byp      = '0;
    byp[2]   = 1'b1;
    hs_count = 0;
    send_cfg(add, byp, r[SW-1:0], 16'd1);
    in_valid = 1'b1;
    rnd_in();
    repeat (3) tick();
    in_valid = 1'b0;
    chk("check_job_accepts", 512'(hs_count), 512'(CheckEn ? 0 : 1));
    wait_idle();

    // Randomized jobs
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 8; i++) r[i * 32 +: 32] = $urandom;
      add = r[AW-1:0];
      byp = (j == 5) ? ~add : (r[2*AW-1:AW] & add);
      send_cfg(add, byp, r[SW-1:0], 16'($urandom_range(0, 6)));
      for (int t = 0; t < 60 && run; t++) begin
        in_valid = ($urandom_range(0, 2) != 0);
        rnd_in();
        tick();
      end
      in_valid = 1'b0;
      wait_idle();
    end
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fan_ctrl.md
FAN_CTRL -- requirements
Module: fan_ctrl

Interface
REQ-001 Parameters SHALL be: DW_DATA, default 8, element width; N, default 32, reduction-tree leaves; TREE_LAT, default 0, register stages inside the attached fan_tree.
REQ-002 Port clk SHALL be: input, 1 bit, single clock; all logic rising-edge.
REQ-003 Port rst SHALL be: input, 1 bit, synchronous active-high reset.
REQ-004 Port cfg_valid / cfg_ready SHALL be: in / out, 1 bit each, job-descriptor handshake.
REQ-005 Ports cfg_add_en and cfg_bypass_en SHALL be: in, N-1 bits each, per-adder enables.
REQ-006 Port cfg_sel SHALL be: in, 6*(N-1) bits, per-adder operand selects.
REQ-007 Port cfg_len SHALL be: in, 16 bits, vector count of the job.
REQ-008 Port in_valid / in_ready SHALL be: in / out, 1 bit each, vector handshake.
REQ-009 Port in_data SHALL be: in, DW_DATA*N bits, one input vector.
REQ-010 Ports fan_add_en, fan_bypass_en and fan_sel SHALL be: out, N-1, N-1 and 6*(N-1) bits, tree configuration.
REQ-011 Port fan_in SHALL be: out, DW_DATA*N bits, registered tree operand.
REQ-012 Port fan_out SHALL be: in, DW_DATA*2*(N-1) bits, tree result.
REQ-013 Ports out_valid, out_last and out_data SHALL be: out, 1, 1 and DW_DATA*2*(N-1) bits, result stream (no backpressure).
REQ-014 Port cfg_err SHALL be: out, 1 bit, rejected-descriptor pulse.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-016 In IDLE, cfg_ready=1 and in_ready=0.
REQ-017 In RUN and DRAIN, cfg_ready=0.
REQ-018 A cfg handshake with cfg_len>0 SHALL latch add_en, bypass_en, sel and len into config registers and move IDLE->RUN.
REQ-019 A cfg handshake with cfg_len=0 SHALL stay in IDLE and pulse out_last for one cycle with out_valid=0.
REQ-020 fan_add_en, fan_bypass_en and fan_sel SHALL be driven from the config registers only, and SHALL be stable from the cycle after the cfg handshake until the FSM reaches IDLE.
REQ-021 In RUN, in_ready=1 while accepted count < len.
REQ-022 The in handshake at edge k SHALL load fan_in at edge k; fan_in SHALL otherwise hold its value.
REQ-023 The result of the edge-k handshake SHALL be registered into out_data at edge k+1+TREE_LAT, with out_valid=1 for exactly one cycle.
REQ-024 Output order SHALL equal input order, and results SHALL be full-rate for back-to-back inputs.
REQ-025 A valid-delay shift register of depth 1+TREE_LAT SHALL track in-flight vectors, each tagged with last = (accepted count == len-1).
REQ-026 Acceptance of the len-th vector SHALL move RUN->DRAIN.
REQ-027 out_last SHALL assert together with the out_valid of the final vector.
REQ-028 On that same edge the FSM SHALL move DRAIN->IDLE, so cfg_ready=1 in the following cycle.
REQ-029 The accepted counter SHALL be 16 bits and SHALL clear on every cfg handshake; no wrap is possible because len ≤ 65535.
REQ-030 in_valid in IDLE or DRAIN SHALL be ignored, and in_data SHALL be don't-care when in_valid=0.

Reset
REQ-031 When rst=1 at an edge, the FSM SHALL go to IDLE, regardless of the current state.
REQ-032 When rst=1 at an edge, the counters, the shift register, the config registers, fan_in, out_data, out_valid, out_last and cfg_err SHALL all go to 0.
REQ-033 A reset mid-job SHALL discard all in-flight results, with no out_valid or out_last afterwards.
REQ-034 cfg_ready SHALL be 1 in the first cycle after rst is released.

Configuration
REQ-035 With macro FAN_CTRL_CHECK_EN defined, a cfg handshake with (cfg_bypass_en & ~cfg_add_en) != 0 SHALL be accepted but not started: the FSM stays in IDLE, the config registers are unchanged, and cfg_err pulses for one cycle.
REQ-036 Without FAN_CTRL_CHECK_EN, no check SHALL be performed and cfg_err SHALL be tied 0.

Verification
REQ-037 Single vector: TREE_LAT=0, add_en all-ones, bypass 0, sel 0, len=1, in_data elements 0..31 -> out_valid, out_last 2 edges after the cfg handshake+1; out_data equals fan_tree golden; cfg_ready=1 the next cycle.
REQ-038 Burst: len=3, in_valid held high -> exactly three in handshakes on consecutive cycles; out_valid on 3 consecutive cycles; out_last only on the third; the 4th in_valid is not accepted (in_ready=0).
REQ-039 Bubbles and latency: TREE_LAT=2, len=4, in_valid toggling 1,0,1,0,... -> each out_valid exactly 3 edges after its handshake; order preserved.
REQ-040 Zero length: cfg_len=0 -> single out_last pulse, out_valid=0, FSM remains IDLE.
REQ-041 Reset mid-job: len=5, rst asserted after 2 accepts with 1 in flight -> no further out_valid; next cycle all outputs 0 and cfg_ready=1.
REQ-042 Check: with FAN_CTRL_CHECK_EN, add_en bit 2=0 and bypass_en bit 2=1 -> cfg_err pulse, in_ready stays 0; without the macro, the job runs normally.
